// File: rtl/clicker_core.sv
// ---------------------------------------------------------------------------
// clicker_core
//   Game engine for the pancake clicker. It holds the score, the upgrade tier
//   and the game state. Clicks, purchases and 1 Hz ticks arrive as
//   single-cycle pulses. The number of tiers, the costs, the click values,
//   the auto-increment rates and the win threshold are all parameters.
//
// Parameters
//   CW        score width in bits
//   TIERS     number of tiers (2..8)
//   COST_BASE cost to leave tier 0
//   COST_MULT cost to leave tier k is COST_BASE*COST_MULT^k
//   CLICK_MAX click value is min(tier+1, CLICK_MAX)
//   AUTO_TIER first tier that earns points on each tick
//   AUTO_RATE per-tick gain is AUTO_RATE*(tier-AUTO_TIER+1)
//   WIN_COUNT score at or above which the game is won
//
// Ports
//   clk       system clock
//   rst       asynchronous active-high reset
//   click     one-cycle click pulse
//   buy       one-cycle purchase pulse
//   tick      one-cycle 1 Hz pulse
//   restart   synchronous return to IDLE; overrides all other inputs
//   count     current score (registered)
//   tier      current tier (registered)
//   next_cost cost of the next upgrade, decoded from tier; 0 at top tier
//   state     0=IDLE, 1=PLAY, 2=WIN (registered)
//   win       high while in WIN (registered)
//   buy_ok    one-cycle pulse when a purchase is accepted
//   buy_rej   one-cycle pulse when a purchase is rejected
// ---------------------------------------------------------------------------
module clicker_core #(
   parameter int CW        = 20,
   parameter int TIERS     = 3,
   parameter int COST_BASE = 10,
   parameter int COST_MULT = 5,
   parameter int CLICK_MAX = 2,
   parameter int AUTO_TIER = 2,
   parameter int AUTO_RATE = 1,
   parameter int WIN_COUNT = 75
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          click,
   input  logic          buy,
   input  logic          tick,
   input  logic          restart,
   output logic [CW-1:0] count,
   output logic [2:0]    tier,
   output logic [CW-1:0] next_cost,
   output logic [1:0]    state,
   output logic          win,
   output logic          buy_ok,
   output logic          buy_rej
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_WIN  = 2'd2
   } state_t;

   // Two spare bits so that count + gain cannot wrap before saturation.
   typedef logic [CW+1:0] ext_t;

   localparam ext_t SAT_MAX = {2'b00, {CW{1'b1}}};

   // Cost of leaving each tier, packed CW bits per tier, built once at
   // elaboration. Slots at or above the top tier stay zero.
   function automatic logic [8*CW-1:0] build_cost_tbl();
      logic [8*CW-1:0] tbl;
      longint          c;
      tbl = '0;
      c   = longint'(COST_BASE);
      for (int k = 0; k < 8; k++) begin
         if (k < TIERS - 1) tbl[k*CW +: CW] = c[CW-1:0];
         c = c * longint'(COST_MULT);
      end
      return tbl;
   endfunction

   function automatic bit params_legal();
      longint lim;
      longint c;
      bit     ok;
      lim = longint'(1) << CW;
      c   = longint'(COST_BASE);
      ok  = (TIERS >= 2) && (TIERS <= 8) && (longint'(WIN_COUNT) < lim);
      for (int k = 0; k < TIERS - 1; k++) begin
         if (c >= lim) ok = 1'b0;
         c = c * longint'(COST_MULT);
      end
      return ok;
   endfunction

   localparam logic [8*CW-1:0] COST_TBL = build_cost_tbl();
   localparam bit              PARAMS_OK = params_legal();

   if (!PARAMS_OK) begin : g_param_check
      $fatal(1, "clicker_core: TIERS out of range, or a cost/WIN_COUNT does not fit in CW bits");
   end

   state_t        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [2:0]    tier_q, tier_d;
   logic          win_q, buy_ok_q, buy_ok_d, buy_rej_q, buy_rej_d;

   int            tier_i, click_i, auto_i;
   ext_t          gain, sum;
   logic [CW-1:0] count_sat;
   logic          accept, reach_win;

   // Cost lookup: a constant-slice table walk, zero at the top tier.
   always_comb begin
      next_cost = '0;
      for (int k = 0; k < TIERS - 1; k++) begin
         if (tier_q == 3'(k)) next_cost = COST_TBL[k*CW +: CW];
      end
   end

   // PLAY arithmetic, evaluated against the current count and tier. A
   // purchase is checked before gain is added, so the subtraction never
   // underflows.
   always_comb begin
      tier_i    = int'(tier_q);
      click_i   = (tier_i + 1 < CLICK_MAX) ? tier_i + 1 : CLICK_MAX;
      auto_i    = (tier_i >= AUTO_TIER) ? AUTO_RATE * (tier_i - AUTO_TIER + 1) : 0;
      gain      = ext_t'(click ? click_i : 0) + ext_t'(tick ? auto_i : 0);
      accept    = buy && (tier_i < TIERS - 1) && (count_q >= next_cost);
      sum       = ext_t'(count_q) + gain - (accept ? ext_t'(next_cost) : ext_t'(0));
      count_sat = (sum > SAT_MAX) ? {CW{1'b1}} : sum[CW-1:0];
      reach_win = ext_t'(count_sat) >= ext_t'(WIN_COUNT);
   end

   // NOTE: every signal driven here gets a default first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      tier_d    = tier_q;
      buy_ok_d  = 1'b0;
      buy_rej_d = 1'b0;
      if (restart) begin
         state_d = S_IDLE;
         count_d = '0;
         tier_d  = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               // The starting click only starts the game; it is not scored.
               if (click) state_d = S_PLAY;
            end
            S_PLAY: begin
               count_d = count_sat;
               if (accept) begin
                  tier_d   = tier_q + 3'd1;
                  buy_ok_d = 1'b1;
               end else if (buy) begin
                  buy_rej_d = 1'b1;
               end
               if (reach_win) state_d = S_WIN;
            end
            S_WIN: begin
               // Frozen until restart or rst.
            end
            default: begin
               state_d = S_IDLE;
               count_d = '0;
               tier_d  = '0;
            end
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values of the others.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         count_q   <= '0;
         tier_q    <= '0;
         win_q     <= 1'b0;
         buy_ok_q  <= 1'b0;
         buy_rej_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         tier_q    <= tier_d;
         win_q     <= (state_d == S_WIN);
         buy_ok_q  <= buy_ok_d;
         buy_rej_q <= buy_rej_d;
      end
   end

   assign count   = count_q;
   assign tier    = tier_q;
   assign state   = state_q;
   assign win     = win_q;
   assign buy_ok  = buy_ok_q;
   assign buy_rej = buy_rej_q;

endmodule
